// File: rtl/dmem_access_stage_pkg.sv
// dmem_access_stage_pkg: shared pipeline definitions for the data-memory access stage.
package dmem_access_stage_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} memState_e;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/dmem_access_stage_wait_ctr.sv
// dmem_wait_ctr: counts BUSY cycles and flags the last cycle allowed before an abort.
module dmem_wait_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic hit_o
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) cnt <= '0;
    else if (en_i) cnt <= cnt + W'(1);
  end
  assign hit_o = en_i && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/dmem_access_stage.sv
// dmem_access_stage: MEM stage that issues one data-memory request per load/store,
// stalling the front of the pipeline until ack or timeout.
module dmem_access_stage
  import dmem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic        writeBack_i,
  input  logic        memtoReg_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] writeData_i,
  input  logic [4:0]  regDstAddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        writeBack_o,
  output logic        memtoReg_o,
  output logic [31:0] memReadData_o,
  output logic [31:0] ALUresult_o,
  output logic [4:0]  regDstAddr_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o
);
  memState_e   state, nextState;
  logic        memReq, hit, start, misal, abort, idle, busy;
  logic        heldRead, heldWe, heldWb, heldMemtoReg;
  logic [31:0] heldAlu, heldWdata, readData;
  logic [4:0]  heldRd;

  dmem_wait_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_waitCtr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (busy),
    .clr_i(!busy || mem_ack_i),
    .hit_o(hit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      memReq       <= 1'b0;
      misalign_o   <= 1'b0;
      timeout_o    <= 1'b0;
      readData     <= '0;
      heldRead     <= 1'b0;
      heldWe       <= 1'b0;
      heldWb       <= 1'b0;
      heldMemtoReg <= 1'b0;
      heldAlu      <= '0;
      heldWdata    <= '0;
      heldRd       <= '0;
    end else begin
      state      <= nextState;
      memReq     <= nextState == BUSY;
      misalign_o <= misal;
      timeout_o  <= abort;
      if (busy && (mem_ack_i || hit)) readData <= (mem_ack_i && heldRead) ? mem_rdata_i : '0;
      if (start) begin
        heldRead     <= memRead_i;
        heldWe       <= memWrite_i;
        heldWb       <= writeBack_i;
        heldMemtoReg <= memtoReg_i;
        heldAlu      <= ALUresult_i;
        heldWdata    <= writeData_i;
        heldRd       <= regDstAddr_i;
      end
    end
  end

  // Ack wins over a timeout landing in the same cycle; ack outside BUSY is ignored.
  always_comb begin
    idle          = state == IDLE;
    busy          = state == BUSY;
    start         = idle && (memRead_i || memWrite_i) && ALUresult_i[1:0] == 2'b00;
    misal         = idle && (memRead_i || memWrite_i) && ALUresult_i[1:0] != 2'b00;
    abort         = busy && hit && !mem_ack_i;
    nextState     = idle ? (start ? BUSY : IDLE) : busy ? ((mem_ack_i || hit) ? DONE : BUSY) : IDLE;
    stall_o       = rst_i && (start || busy);
    writeBack_o   = rst_i && !stall_o && (idle ? writeBack_i && !misal : heldWb && !timeout_o);
    memtoReg_o    = idle ? memtoReg_i : heldMemtoReg;
    ALUresult_o   = idle ? ALUresult_i : heldAlu;
    regDstAddr_o  = idle ? regDstAddr_i : heldRd;
    memReadData_o = idle ? 32'd0 : readData;
    mem_req_o     = memReq;
    mem_we_o      = memReq && heldWe;
    mem_addr_o    = {heldAlu[31:2], 2'b00};
    mem_wdata_o   = heldWdata;
  end
endmodule

// File: tb/tb_dmem_access_stage.sv
// tb_dmem_access_stage: directed vectors for the pass-through/misalign paths plus
// hand-written multi-cycle sequences for load, store, timeout, reset and back-to-back.
module tb_dmem_access_stage;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        memRead_i = 1'b0, memWrite_i = 1'b0, writeBack_i = 1'b0, memtoReg_i = 1'b0;
  logic [31:0] ALUresult_i = '0, writeData_i = '0, mem_rdata_i = '0;
  logic [4:0]  regDstAddr_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        mem_req_o, mem_we_o, writeBack_o, memtoReg_o, stall_o, misalign_o, timeout_o;
  logic [31:0] mem_addr_o, mem_wdata_o, memReadData_o, ALUresult_o;
  logic [4:0]  regDstAddr_o;
  int checks = 0, errors = 0;

  dmem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i), .writeBack_i(writeBack_i),
    .memtoReg_i(memtoReg_i), .ALUresult_i(ALUresult_i), .writeData_i(writeData_i),
    .regDstAddr_i(regDstAddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .writeBack_o(writeBack_o), .memtoReg_o(memtoReg_o), .memReadData_o(memReadData_o),
    .ALUresult_o(ALUresult_o), .regDstAddr_o(regDstAddr_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic mr, mw, wb, m2r;
    logic [31:0] alu;
    logic [4:0] rd;
    logic eWb, eMis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setIn(input logic mr, input logic mw, input logic wb, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    memRead_i = mr; memWrite_i = mw; writeBack_i = wb; memtoReg_i = m2r;
    ALUresult_i = alu; writeData_i = wd; regDstAddr_i = rd;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, " req"}, mem_req_o, 0);
    chk({tag, " timeout"}, timeout_o, 0);
    chk({tag, " misalign"}, misalign_o, 0);
  endtask

  vec_t vecs[6];
  int stallCnt;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0007, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0041, 5'd3,  1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0012, 5'd0,  1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 5'd0,  1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0043, 5'd9,  1'b0, 1'b1};

    // Reset with an aligned load presented: outputs must stay quiet.
    setIn(1, 0, 1, 1, 32'h40, 0, 5'd1);
    @(negedge clk_i); @(negedge clk_i); #1;
    chk("rst stall", stall_o, 0);
    chk("rst wb", writeBack_o, 0);
    chkIdle("rst");
    @(negedge clk_i);
    setIn(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;

    // Table: IDLE pass-through and misaligned accesses.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      setIn(vecs[i].mr, vecs[i].mw, vecs[i].wb, vecs[i].m2r, vecs[i].alu, 32'hAAAA_5555, vecs[i].rd);
      #1;
      chk($sformatf("v%0d stall", i), stall_o, 0);
      chk($sformatf("v%0d wb", i), writeBack_o, vecs[i].eWb);
      chk($sformatf("v%0d m2r", i), memtoReg_o, vecs[i].m2r);
      chk($sformatf("v%0d alu", i), ALUresult_o, vecs[i].alu);
      chk($sformatf("v%0d rd", i), regDstAddr_o, vecs[i].rd);
      chk($sformatf("v%0d mrd", i), memReadData_o, 0);
      @(negedge clk_i);
      chk($sformatf("v%0d misalign", i), misalign_o, vecs[i].eMis);
      chk($sformatf("v%0d req", i), mem_req_o, 0);
      setIn(0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk_i);
    chk("misalign drop", misalign_o, 0);

    // Load at 0x40, ack in the second BUSY cycle.
    setIn(1, 0, 1, 1, 32'h40, 0, 5'd7);
    stallCnt = 0;
    #1; stallCnt += int'(stall_o);
    chk("ld detect req", mem_req_o, 0);
    chk("ld detect wb", writeBack_o, 0);
    @(negedge clk_i); #1; stallCnt += int'(stall_o);
    chk("ld b1 req", mem_req_o, 1);
    chk("ld b1 we", mem_we_o, 0);
    chk("ld b1 addr", mem_addr_o, 32'h40);
    chk("ld b1 wb", writeBack_o, 0);
    @(negedge clk_i);
    mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    #1; stallCnt += int'(stall_o);
    chk("ld b2 req", mem_req_o, 1);
    @(negedge clk_i);
    mem_ack_i = 0; mem_rdata_i = 0;
    #1; stallCnt += int'(stall_o);
    chk("ld stall cycles", stallCnt, 3);
    chk("ld done req", mem_req_o, 0);
    chk("ld done data", memReadData_o, 32'hDEAD_BEEF);
    chk("ld done wb", writeBack_o, 1);
    chk("ld done m2r", memtoReg_o, 1);
    chk("ld done rd", regDstAddr_o, 7);
    chk("ld done alu", ALUresult_o, 32'h40);

    // Store at 0x10, ack in the first BUSY cycle.
    @(negedge clk_i);
    setIn(0, 1, 0, 0, 32'h10, 32'h1234_5678, 5'd2);
    #1;
    chk("st detect stall", stall_o, 1);
    @(negedge clk_i);
    mem_ack_i = 1; mem_rdata_i = 32'hFFFF_0000;
    #1;
    chk("st b1 req", mem_req_o, 1);
    chk("st b1 we", mem_we_o, 1);
    chk("st b1 wdata", mem_wdata_o, 32'h1234_5678);
    chk("st b1 addr", mem_addr_o, 32'h10);
    chk("st b1 stall", stall_o, 1);
    @(negedge clk_i);
    mem_ack_i = 0; mem_rdata_i = 0;
    #1;
    chk("st done stall", stall_o, 0);
    chk("st done req", mem_req_o, 0);
    chk("st done wb", writeBack_o, 0);
    chk("st done data", memReadData_o, 0);

    // Load that never gets acked: abort after 4 BUSY cycles.
    @(negedge clk_i);
    setIn(1, 0, 1, 1, 32'h80, 0, 5'd4);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i); #1;
      chk($sformatf("to b%0d req", c), mem_req_o, 1);
      chk($sformatf("to b%0d stall", c), stall_o, 1);
      chk($sformatf("to b%0d timeout", c), timeout_o, 0);
    end
    @(negedge clk_i); #1;
    chk("to done req", mem_req_o, 0);
    chk("to done timeout", timeout_o, 1);
    chk("to done wb", writeBack_o, 0);
    chk("to done data", memReadData_o, 0);
    chk("to done stall", stall_o, 0);
    @(negedge clk_i);
    setIn(0, 0, 0, 0, 0, 0, 0);
    mem_ack_i = 1; mem_rdata_i = 32'h1111_2222;
    #1;
    chk("late ack stall", stall_o, 0);
    chkIdle("late ack");
    @(negedge clk_i);
    mem_ack_i = 0;
    #1;
    chkIdle("after late ack");
    chk("after late ack mrd", memReadData_o, 0);

    // Reset in the second BUSY cycle, then a stray ack.
    @(negedge clk_i);
    setIn(1, 0, 1, 0, 32'h20, 0, 5'd8);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst busy stall", stall_o, 0);
    chk("rst busy wb", writeBack_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0);
    mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    chkIdle("post rst");
    chk("post rst stall", stall_o, 0);
    chk("post rst wb", writeBack_o, 0);
    @(negedge clk_i);
    mem_ack_i = 0;
    #1;
    chkIdle("post rst ack");
    chk("post rst mrd", memReadData_o, 0);

    // ALU op, load, ALU op back to back.
    @(negedge clk_i);
    setIn(0, 0, 1, 0, 32'h7, 0, 5'd5);
    #1;
    chk("b2b alu1 stall", stall_o, 0);
    chk("b2b alu1 wb", writeBack_o, 1);
    chk("b2b alu1 rd", regDstAddr_o, 5);
    chk("b2b alu1 res", ALUresult_o, 32'h7);
    @(negedge clk_i);
    setIn(1, 0, 1, 1, 32'h44, 0, 5'd9);
    #1;
    chk("b2b ld stall", stall_o, 1);
    @(negedge clk_i);
    mem_ack_i = 1; mem_rdata_i = 32'hA5A5_A5A5;
    #1;
    chk("b2b busy stall", stall_o, 1);
    @(negedge clk_i);
    mem_ack_i = 0; mem_rdata_i = 0;
    #1;
    chk("b2b done stall", stall_o, 0);
    chk("b2b done rd", regDstAddr_o, 9);
    chk("b2b done data", memReadData_o, 32'hA5A5_A5A5);
    chk("b2b done wb", writeBack_o, 1);
    @(negedge clk_i);
    setIn(0, 0, 1, 0, 32'h99, 0, 5'd6);
    #1;
    chk("b2b alu2 stall", stall_o, 0);
    chk("b2b alu2 wb", writeBack_o, 1);
    chk("b2b alu2 rd", regDstAddr_o, 6);
    chk("b2b alu2 res", ALUresult_o, 32'h99);
    chk("b2b alu2 mrd", memReadData_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_stage.md
DMEM_ACCESS_STAGE -- requirements
Module: dmem_access_stage

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 64, the maximum number of BUSY cycles to wait for mem_ack_i before aborting.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-low
- memRead_i  in  1  EX/MEM load control
- memWrite_i  in  1  EX/MEM store control
- writeBack_i  in  1  EX/MEM register-write control
- memtoReg_i  in  1  EX/MEM result-select control
- ALUresult_i  in  32  EX/MEM ALU result, also used as byte address
- writeData_i  in  32  EX/MEM store data
- regDstAddr_i  in  5  EX/MEM destination register
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  1 = write request
- mem_addr_o  out  32  word-aligned request address
- mem_wdata_o  out  32  store data
- mem_ack_i  in  1  one-cycle memory completion
- mem_rdata_i  in  32  load data, valid with mem_ack_i
- writeBack_o, memtoReg_o  out  1 each  to MEM/WB register
- memReadData_o  out  32  to MEM/WB register
- ALUresult_o  out  32  to MEM/WB register
- regDstAddr_o  out  5  to MEM/WB register
- stall_o  out  1  holds PC, IF/ID, ID/EX and EX/MEM
- misalign_o  out  1  one-cycle pulse on misaligned access
- timeout_o  out  1  one-cycle pulse on aborted access

Function
REQ-003 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-004 In IDLE with memRead_i|memWrite_i=1 and ALUresult_i[1:0]=0, the FSM SHALL go to BUSY, and stall_o SHALL be 1 combinationally in that same cycle.
REQ-005 In IDLE with a memory access and ALUresult_i[1:0]!=0, the block SHALL stay in IDLE, issue no request, pulse misalign_o for one cycle and force writeBack_o=0.
REQ-006 In IDLE with no access, the block SHALL pass every EX/MEM field through to the MEM/WB outputs combinationally, and memReadData_o SHALL be 0.
REQ-007 In BUSY, the registered mem_req_o SHALL be 1, and mem_we_o, mem_addr_o and mem_wdata_o SHALL stay stable until the request ends.
REQ-008 In BUSY, stall_o SHALL be 1 and writeBack_o SHALL be 0 (bubble).
REQ-009 In BUSY with mem_ack_i=1, the block SHALL capture mem_rdata_i into an internal register (loads only, stores capture 0), deassert mem_req_o and go to DONE.
REQ-010 In DONE, which lasts exactly one cycle, stall_o SHALL be 0.
REQ-011 In DONE, the outputs SHALL carry the held EX/MEM fields plus the captured read data, and the FSM SHALL then return to IDLE.
REQ-012 Minimum access latency SHALL be 3 cycles from the IDLE detect cycle to the MEM/WB capture at the end of DONE, with ack arriving in the first BUSY cycle.
REQ-013 A wait counter SHALL count BUSY cycles.
REQ-014 When the wait counter reaches TIMEOUT_CYCLES without an ack, the block SHALL drop mem_req_o, pulse timeout_o, go to DONE with writeBack_o forced 0 and captured data 0, and clear the counter.
REQ-015 An ack and a timeout in the same cycle SHALL resolve as an ack.
REQ-016 mem_ack_i SHALL be ignored in IDLE and DONE, so a late ack after an abort or reset has no effect.
REQ-017 Back-to-back accesses SHALL be handled: the instruction following DONE is evaluated in IDLE on the next cycle, with no extra gap.

Reset
REQ-018 While rst_i=0 at a clock edge, the state SHALL become IDLE, and the counter, capture register, mem_req_o, misalign_o and timeout_o SHALL become 0.
REQ-019 A reset during BUSY SHALL abandon the access with no writeback and no error pulse.
REQ-020 While reset is asserted, stall_o SHALL be 0 and writeBack_o SHALL be 0.

Structure
REQ-021 The state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the TIMEOUT_CYCLES default SHALL reside in a shared pipeline definitions package.
REQ-022 The wait counter SHALL be a separate sub-module, dmem_wait_ctr, with inputs clk_i, rst_i, en_i and clr_i and a 1-bit output hit_o.

Verification
REQ-023 Load, addr 0x40, ack on the 2nd BUSY cycle with rdata 0xDEADBEEF -> stall_o high for 3 cycles; in DONE, memReadData_o=0xDEADBEEF and writeBack_o=1.
REQ-024 Store, addr 0x10, wdata 0x12345678, ack on the 1st BUSY cycle -> mem_we_o=1, mem_wdata_o=0x12345678 stable until ack; writeBack_o stays at writeBack_i (0).
REQ-025 Load at addr 0x41 -> no mem_req_o, misalign_o pulses once, writeBack_o=0, stall_o=0.
REQ-026 Load with no ack and TIMEOUT_CYCLES=4 -> mem_req_o high for 4 cycles, timeout_o pulses, DONE has writeBack_o=0; an ack injected afterwards is ignored.
REQ-027 Reset in the 2nd BUSY cycle, then ack on the next cycle -> state IDLE, mem_req_o=0, no writeback, no pulses.
REQ-028 ALU op (regDst 5, result 0x7), then a load, then another ALU op -> first op passes through in 0 cycles, the load stalls, and the second op follows DONE with no gap.
